// File: rtl/image_fetch.sv
// Streams a W x H frame out of a synchronous pixel RAM in raster order, with a
// 2-deep output FIFO plus one in-flight read so the downstream core can stall freely.
module image_fetch #(
    parameter int PIX_W  = 8,
    parameter int DIM_W  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_op,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [PIX_W-1:0]  ram_rd_data,
    output logic [PIX_W-1:0]  out_pixel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sol,
    output logic              out_eof,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t r_state, w_next;

    logic [DIM_W-1:0]       r_w, r_h, r_col, r_row;
    logic [ADDR_W-1:0]      r_base, r_k, r_addr_last, w_addr;
    logic                   r_infl, r_infl_sol, r_infl_eof;
    logic [1:0][PIX_W-1:0]  r_mem_pix;
    logic [1:0]             r_mem_sol, r_mem_eof;
    logic                   r_wp, r_rp;
    logic [1:0]             r_cnt, w_occ;
    logic                   w_pop, w_rd_en, w_col_end, w_last, w_start;

    // Occupancy after this edge: stored pixels plus the returning read, minus the pop.
    assign w_pop     = out_valid & out_ready;
    assign w_occ     = r_cnt + {1'b0, r_infl} - {1'b0, w_pop};
    assign w_rd_en   = (r_state == S_FETCH) && (w_occ < 2'd2);
    assign w_col_end = (r_col == r_w - 1'b1);
    assign w_last    = w_col_end && (r_row == r_h - 1'b1);
    assign w_addr    = r_base + r_k;
    assign w_start   = (r_state == S_IDLE) && start_op;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_op)
                         w_next = (width == '0 || height == '0) ? S_DONE : S_FETCH;
            S_FETCH: if (w_rd_en && w_last) w_next = S_DRAIN;
            S_DRAIN: if (w_occ == 2'd0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_w         <= '0;
            r_h         <= '0;
            r_base      <= '0;
            r_k         <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_addr_last <= '0;
            r_infl      <= 1'b0;
            r_infl_sol  <= 1'b0;
            r_infl_eof  <= 1'b0;
        end else begin
            if (w_start) begin
                r_w    <= width;
                r_h    <= height;
                r_base <= base_addr;
                r_k    <= '0;
                r_col  <= '0;
                r_row  <= '0;
            end else if (w_rd_en) begin
                r_k <= r_k + 1'b1;
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            r_infl <= w_rd_en;
            if (w_rd_en) begin
                r_addr_last <= w_addr;
                r_infl_sol  <= (r_col == '0);
                r_infl_eof  <= w_last;
            end
        end
    end

    // Returning data always finds a free slot because issue is throttled on w_occ.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mem_pix <= '0;
            r_mem_sol <= '0;
            r_mem_eof <= '0;
            r_wp      <= 1'b0;
            r_rp      <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (r_infl) begin
                r_mem_pix[r_wp] <= ram_rd_data;
                r_mem_sol[r_wp] <= r_infl_sol;
                r_mem_eof[r_wp] <= r_infl_eof;
                r_wp            <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_cnt <= w_occ;
        end
    end

    assign out_valid = (r_cnt != 2'd0);
    assign out_pixel = out_valid ? r_mem_pix[r_rp] : '0;
    assign out_sol   = out_valid & r_mem_sol[r_rp];
    assign out_eof   = out_valid & r_mem_eof[r_rp];
    assign ram_rd_en = w_rd_en;
    assign ram_addr  = w_rd_en ? w_addr : r_addr_last;
    assign busy      = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_image_fetch.sv
// Randomized scoreboard bench for image_fetch: expected addresses and pixels are
// queued at frame start from the raster rules; a negedge monitor pops and compares.
module tb_image_fetch;

    logic        clk = 1'b0, rstn = 1'b0, start_op = 1'b0, out_ready = 1'b0;
    logic [7:0]  width = '0, height = '0, ram_rd_data = '0, out_pixel;
    logic [15:0] base_addr = '0, ram_addr;
    logic        ram_rd_en, out_valid, out_sol, out_eof, busy, done;

    int total = 0, bad = 0, cyc = 0, done_cnt = 0, xfer_cnt = 0, outstanding = 0;
    int rdy_mode = 0, ram_mode = 0;
    logic [15:0] exp_addr[$];
    logic [9:0]  exp_pix[$];
    int          stamps[$];
    logic        hold_v = 1'b0, eof_pend = 1'b0;
    logic [9:0]  held = '0;

    image_fetch #(.PIX_W(8), .DIM_W(8), .ADDR_W(16)) dut (
        .clk(clk), .rstn(rstn), .start_op(start_op), .width(width), .height(height),
        .base_addr(base_addr), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
        .ram_rd_data(ram_rd_data), .out_pixel(out_pixel), .out_valid(out_valid),
        .out_ready(out_ready), .out_sol(out_sol), .out_eof(out_eof), .busy(busy), .done(done)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    function automatic logic [7:0] ram_val(input logic [15:0] a);
        if (ram_mode == 0) return a[7:0];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Synchronous RAM: data one cycle after the read strobe.
    always @(posedge clk) if (ram_rd_en) ram_rd_data <= ram_val(ram_addr);

    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] got);
        total++;
        bad++;
        $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, got, cyc);
    endtask

    // Monitor / scoreboard
    initial forever begin
        int xf;
        @(negedge clk);
        if (!rstn) begin
            exp_addr.delete();
            exp_pix.delete();
            outstanding = 0;
            hold_v      = 1'b0;
            eof_pend    = 1'b0;
        end else begin
            xf = int'(out_valid && out_ready);
            if (eof_pend) check("done_after_eof", done, 1);
            eof_pend = 1'b0;
            if (done) done_cnt++;
            if (hold_v) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {out_pixel, out_sol, out_eof}, held);
            end
            if (ram_rd_en) begin
                if (exp_addr.size() == 0) fail("rd_spurious", ram_addr);
                else check("rd_addr", ram_addr, exp_addr.pop_front());
                check("rd_room", 32'(outstanding + 1 - xf <= 2), 1);
            end
            if (xf != 0) begin
                if (exp_pix.size() == 0) fail("pix_spurious", {out_pixel, out_sol, out_eof});
                else check("pixel", {out_pixel, out_sol, out_eof}, exp_pix.pop_front());
                stamps.push_back(cyc);
                xfer_cnt++;
                if (out_eof) eof_pend = 1'b1;
            end
            outstanding += int'(ram_rd_en) - xf;
            hold_v = out_valid && !out_ready;
            held   = {out_pixel, out_sol, out_eof};
        end
    end

    task automatic push_frame(input int w, input int h, input logic [15:0] b);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                int k = r * w + c;
                logic [15:0] a = b + 16'(k);
                exp_addr.push_back(a);
                exp_pix.push_back({ram_val(a), c == 0, k == w * h - 1});
            end
    endtask

    // Drives start for one sampling edge; returns 1 time unit after that edge.
    task automatic start_frame(input int w, input int h, input logic [15:0] b, input bit hold);
        @(posedge clk); #1;
        width     = 8'(w);
        height    = 8'(h);
        base_addr = b;
        start_op  = 1'b1;
        push_frame(w, h, b);
        @(posedge clk); #1;
        if (!hold) start_op = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input bit chk_q);
        int n = 0;
        while (done_cnt < target && n < budget) begin @(posedge clk); n++; end
        check("done_count", done_cnt, target);
        if (chk_q) begin
            check("pix_left", exp_pix.size(), 0);
            check("addr_left", exp_addr.size(), 0);
        end
    endtask

    initial begin
        int d0, x0, n;
        logic [15:0] b;

        #1;
        check("reset_outs", {ram_rd_en, ram_addr, out_valid, out_pixel, out_sol, out_eof, busy, done}, 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Basic frame, ready high: latency, throughput, sol/eof, single done
        ram_mode = 0; rdy_mode = 0;
        repeat (2) @(posedge clk);
        stamps.delete();
        d0 = done_cnt;
        start_frame(4, 3, 16'h0100, 0);
        check("lat_rd_en", ram_rd_en, 1);
        check("lat_v0", out_valid, 0);
        @(posedge clk); #1 check("lat_v1", out_valid, 0);
        @(posedge clk); #1 check("lat_v2", out_valid, 1);
        wait_done(d0 + 1, 100, 1);
        check("t1_xfers", stamps.size(), 12);
        if (stamps.size() == 12) check("t1_span", stamps[11] - stamps[0], 11);
        repeat (4) @(posedge clk);
        check("t1_done_once", done_cnt, d0 + 1);

        // Same frame with ready toggling
        rdy_mode = 1;
        d0 = done_cnt;
        start_frame(4, 3, 16'h0100, 0);
        wait_done(d0 + 1, 200, 1);

        // Zero-width frame: no reads, immediate done
        d0 = done_cnt;
        start_frame(0, 5, 16'h0040, 0);
        wait_done(d0 + 1, 3, 1);
        @(posedge clk); #1 check("t3_busy", busy, 0);

        // Address wrap past 0xFFFF
        rdy_mode = 2;
        d0 = done_cnt;
        start_frame(4, 1, 16'hFFFE, 0);
        wait_done(d0 + 1, 100, 1);

        // Reset mid-frame, then a full 28x28 frame
        ram_mode = 1;
        b  = 16'($urandom_range(0, 65535));
        d0 = done_cnt;
        x0 = xfer_cnt;
        start_frame(28, 28, b, 0);
        n = 0;
        while (xfer_cnt < x0 + 5 && n < 200) begin @(posedge clk); n++; end
        check("t5_five_px", 32'(xfer_cnt >= x0 + 5), 1);
        @(posedge clk); #2 rstn = 1'b0;
        #1 check("t5_reset_outs",
                 {ram_rd_en, ram_addr, out_valid, out_pixel, out_sol, out_eof, busy, done}, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("t5_no_done", done_cnt, d0);
        check("t5_idle", busy, 0);
        start_frame(28, 28, b, 0);
        wait_done(d0 + 1, 5000, 1);

        // Mid-frame changes ignored; held start re-arms right after done
        ram_mode = 0; rdy_mode = 2;
        d0 = done_cnt;
        start_frame(5, 4, 16'h2000, 0);
        repeat (5) @(posedge clk);
        #1 width = 8'd9; height = 8'd9; base_addr = 16'h7000; start_op = 1'b1;
        @(posedge clk); #1 start_op = 1'b0;
        repeat (2) @(posedge clk);
        #1 width = 8'd3; height = 8'd2; base_addr = 16'h3000; start_op = 1'b1;
        push_frame(3, 2, 16'h3000);
        wait_done(d0 + 1, 300, 0);
        @(posedge clk); #1 start_op = 1'b0;
        check("t6_rearm_busy", busy, 1);
        wait_done(d0 + 2, 300, 1);

        // Random frames
        for (int f = 0; f < 4; f++) begin
            ram_mode = f % 2;
            d0 = done_cnt;
            start_frame($urandom_range(1, 12), $urandom_range(1, 12),
                        16'($urandom_range(0, 65535)), 0);
            wait_done(d0 + 1, 1000, 1);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
